commit_tracker: RTL and testbench

Parametrised multi-lane retirement monitor that sits between the core's writeback/commit point and the difftest commit, trap and counter interfaces. It accepts up to `LANES` in-order retirement records per cycle and registers them onto per-lane commit outputs. It suppresses architecturally meaningless writes, flags the boot instruction for skip, and maintains cycle and instruction counters. It detects the trap instruction and halts cleanly, and can optionally flag a hang when commits stop.

---
 rtl/commit_tracker_if.sv | 32 +++
 rtl/commit_tracker.sv | 207 ++++++++++++++++++++
 tb/tb_commit_tracker.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_tracker_if.sv
// Retirement bus between the core's commit point and the tracker.
// The master side drives the in_* retirement records and observes the
// registered out_* commit records. The slave side (the tracker) does the reverse.
interface commit_tracker_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 64
);
    logic [LANES-1:0]      in_valid;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES*32-1:0]   in_inst;
    logic [LANES-1:0]      in_wen;
    logic [LANES*5-1:0]    in_wdest;
    logic [LANES*XLEN-1:0] in_wdata;

    logic [LANES-1:0]      out_valid;
    logic [LANES*XLEN-1:0] out_pc;
    logic [LANES*32-1:0]   out_inst;
    logic [LANES*XLEN-1:0] out_wdata;
    logic [LANES-1:0]      out_wen;
    logic [LANES*8-1:0]    out_wdest;
    logic [LANES-1:0]      out_skip;

    modport master (
        output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata,
        input  out_valid, out_pc, out_inst, out_wdata, out_wen, out_wdest, out_skip
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata,
        output out_valid, out_pc, out_inst, out_wdata, out_wen, out_wdest, out_skip
    );
endinterface

// File: rtl/commit_tracker.sv
// commit_tracker: multi-lane in-order retirement monitor.
// Registers accepted retirement lanes onto commit outputs, masks writes to x0,
// flags the boot instruction for skip, counts cycles and instructions, and halts
// after the trap instruction commits.
// Optional feature macro: COMMIT_WATCHDOG_EN enables an idle watchdog that raises
// a sticky hang flag and forces a trap (code 8'hFF) after TIMEOUT idle cycles.
module commit_tracker #(
    parameter int              LANES       = 2,
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] PC_START    = XLEN'(64'h8000_0000),
    parameter logic [6:0]      TRAP_OPCODE = 7'h6b,
    parameter int              TIMEOUT     = 5000
) (
    input  logic             clock,
    input  logic             reset,
    commit_tracker_if.slave  bus,
    input  logic [7:0]       trap_code_src,
    output logic             trap_valid,
    output logic [7:0]       trap_code,
    output logic [XLEN-1:0]  trap_pc,
    output logic [63:0]      cycle_cnt,
    output logic [63:0]      instr_cnt,
    output logic             halted,
    output logic             hang
);

    typedef enum logic [1:0] {RUN, TRAP, HALTED} state_t;

    state_t            state_reg;
    logic              skip_armed_reg;
    logic [63:0]       cycle_cnt_reg;
    logic [63:0]       instr_cnt_reg;
    logic              trap_valid_reg;
    logic [7:0]        trap_code_reg;
    logic [XLEN-1:0]   trap_pc_reg;
    logic              halted_reg;

    logic [LANES-1:0]  lane_trap;
    logic [LANES-1:0]  accept;
    logic [3:0]        accept_cnt;
    logic              trap_hit;
    logic [XLEN-1:0]   trap_pc_next;
    logic [XLEN-1:0]   last_pc_next;
    logic              chain_open;

    // Per-lane trap opcode decode
    for (genvar gi = 0; gi < LANES; gi++) begin : g_decode
        assign lane_trap[gi] = (bus.in_inst[gi*32 +: 7] == TRAP_OPCODE);
    end

    // Walk lanes in order: accept until the first gap or just past the first trap
    always_comb begin
        accept       = '0;
        accept_cnt   = '0;
        trap_hit     = 1'b0;
        trap_pc_next = '0;
        last_pc_next = '0;
        chain_open   = (state_reg == RUN);
        for (int i = 0; i < LANES; i++) begin
            if (chain_open && bus.in_valid[i]) begin
                accept[i]    = 1'b1;
                accept_cnt   = accept_cnt + 4'd1;
                last_pc_next = bus.in_pc[i*XLEN +: XLEN];
                if (lane_trap[i]) begin
                    trap_hit     = 1'b1;
                    trap_pc_next = bus.in_pc[i*XLEN +: XLEN];
                    chain_open   = 1'b0;
                end
            end else begin
                chain_open = 1'b0;
            end
        end
    end

    // Per-lane commit registers; non-accepted lanes present all-zero records
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic            valid_reg;
        logic            wen_reg;
        logic            skip_reg;
        logic [XLEN-1:0] pc_reg;
        logic [XLEN-1:0] wdata_reg;
        logic [31:0]     inst_reg;
        logic [4:0]      wdest_reg;
        logic            skip_hit;

        // Only lane 0 can hold the first instruction since reset
        if (gi == 0) begin : g_first
            assign skip_hit = skip_armed_reg && (bus.in_pc[XLEN-1:0] == PC_START);
        end else begin : g_rest
            assign skip_hit = 1'b0;
        end

        // Capture the lane's record when it is accepted
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_reg <= 1'b0;
                wen_reg   <= 1'b0;
                skip_reg  <= 1'b0;
                pc_reg    <= '0;
                wdata_reg <= '0;
                inst_reg  <= '0;
                wdest_reg <= '0;
            end else begin
                valid_reg <= accept[gi];
                wen_reg   <= accept[gi] && bus.in_wen[gi] && (bus.in_wdest[gi*5 +: 5] != 5'd0);
                skip_reg  <= accept[gi] && skip_hit;
                pc_reg    <= accept[gi] ? bus.in_pc[gi*XLEN +: XLEN]    : '0;
                wdata_reg <= accept[gi] ? bus.in_wdata[gi*XLEN +: XLEN] : '0;
                inst_reg  <= accept[gi] ? bus.in_inst[gi*32 +: 32]      : '0;
                wdest_reg <= accept[gi] ? bus.in_wdest[gi*5 +: 5]       : '0;
            end
        end

        assign bus.out_valid[gi]              = valid_reg;
        assign bus.out_wen[gi]                = wen_reg;
        assign bus.out_skip[gi]               = skip_reg;
        assign bus.out_pc[gi*XLEN +: XLEN]    = pc_reg;
        assign bus.out_wdata[gi*XLEN +: XLEN] = wdata_reg;
        assign bus.out_inst[gi*32 +: 32]      = inst_reg;
        assign bus.out_wdest[gi*8 +: 8]       = {3'b000, wdest_reg};
    end

`ifdef COMMIT_WATCHDOG_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_reg;
    logic              hang_reg;
    logic [XLEN-1:0]   last_pc_reg;
    logic              wd_fire;

    // Fires on the idle cycle that brings the idle count up to TIMEOUT
    assign wd_fire = (accept_cnt == 4'd0) && (idle_reg == IDLE_W'(TIMEOUT - 1));
    assign hang    = hang_reg;
`else
    logic unused_cfg;

    assign unused_cfg = (^TIMEOUT) ^ (^last_pc_next);
    assign hang       = 1'b0;
`endif

    // Control FSM, counters and trap capture
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= RUN;
            skip_armed_reg <= 1'b1;
            cycle_cnt_reg  <= '0;
            instr_cnt_reg  <= '0;
            trap_valid_reg <= 1'b0;
            trap_code_reg  <= '0;
            trap_pc_reg    <= '0;
            halted_reg     <= 1'b0;
`ifdef COMMIT_WATCHDOG_EN
            idle_reg       <= '0;
            hang_reg       <= 1'b0;
            last_pc_reg    <= '0;
`endif
        end else begin
            trap_valid_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
                    instr_cnt_reg <= instr_cnt_reg + 64'(accept_cnt);
                    if (accept_cnt != 4'd0) begin
                        skip_armed_reg <= 1'b0;
                    end
                    if (trap_hit) begin
                        state_reg      <= TRAP;
                        trap_valid_reg <= 1'b1;
                        trap_code_reg  <= trap_code_src;
                        trap_pc_reg    <= trap_pc_next;
                    end
`ifdef COMMIT_WATCHDOG_EN
                    else if (wd_fire) begin
                        state_reg      <= TRAP;
                        trap_valid_reg <= 1'b1;
                        trap_code_reg  <= 8'hFF;
                        trap_pc_reg    <= last_pc_reg;
                        hang_reg       <= 1'b1;
                    end
                    if (accept_cnt != 4'd0) begin
                        idle_reg    <= '0;
                        last_pc_reg <= last_pc_next;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
`endif
                end
                TRAP: begin
                    cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
                    state_reg     <= HALTED;
                    halted_reg    <= 1'b1;
                end
                default: begin
                    // HALTED: everything frozen until reset
                end
            endcase
        end
    end

    assign trap_valid = trap_valid_reg;
    assign trap_code  = trap_code_reg;
    assign trap_pc    = trap_pc_reg;
    assign cycle_cnt  = cycle_cnt_reg;
    assign instr_cnt  = instr_cnt_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_commit_tracker.sv
// Testbench for commit_tracker (LANES=2, XLEN=64, TIMEOUT=8).
// Directed vector table plus randomized traffic against a behavioural model.
// The watchdog sequence is compiled in when COMMIT_WATCHDOG_EN is defined.
module tb_commit_tracker;

    localparam int          LANES    = 2;
    localparam int          XLEN     = 64;
    localparam int          TIMEOUT  = 8;
    localparam logic [63:0] PC_START = 64'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] TRAPI    = 32'h0000_006b;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  trap_code_src = 8'h00;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    logic        halted;
    logic        hang;

    commit_tracker_if #(.LANES(LANES), .XLEN(XLEN)) bus ();

    commit_tracker #(
        .LANES(LANES), .XLEN(XLEN), .PC_START(PC_START),
        .TRAP_OPCODE(7'h6b), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .trap_code_src(trap_code_src), .trap_valid(trap_valid),
        .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .halted(halted), .hang(hang)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- behavioural model ----------------
    int           m_state;   // 0 running, 1 trap cycle, 2 halted
    bit           m_armed;
    int           m_idle;
    logic [63:0]  m_cycle, m_instr, m_last_pc;
    logic [1:0]   e_valid, e_skip, e_wen;
    logic [127:0] e_pc, e_wdata;
    logic [63:0]  e_inst;
    logic [15:0]  e_wdest;
    logic         e_trapv, e_hang;
    logic [7:0]   e_code;
    logic [63:0]  e_tpc;

    task automatic model_step(input bit rst);
        int          n;
        bit          trapped;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  wd;
        e_valid = '0; e_skip = '0; e_wen = '0; e_pc = '0; e_wdata = '0;
        e_inst = '0; e_wdest = '0; e_trapv = 1'b0;
        if (rst) begin
            m_state = 0; m_armed = 1; m_idle = 0; m_cycle = 0; m_instr = 0;
            m_last_pc = 0; e_code = 0; e_tpc = 0; e_hang = 0;
            return;
        end
        if (m_state == 2) return;
        m_cycle = m_cycle + 1;
        if (m_state == 1) begin
            m_state = 2;
            return;
        end
        n = 0;
        trapped = 0;
        for (int i = 0; i < LANES; i++) begin
            if (!bus.in_valid[i] || trapped) break;
            n++;
            pc   = bus.in_pc[i*64 +: 64];
            inst = bus.in_inst[i*32 +: 32];
            wd   = bus.in_wdest[i*5 +: 5];
            e_valid[i]          = 1'b1;
            e_pc[i*64 +: 64]    = pc;
            e_wdata[i*64 +: 64] = bus.in_wdata[i*64 +: 64];
            e_inst[i*32 +: 32]  = inst;
            e_wdest[i*8 +: 8]   = {3'b000, wd};
            e_wen[i]            = bus.in_wen[i] && (wd != 0);
            if (m_armed && pc == PC_START) e_skip[i] = 1'b1;
            m_armed   = 0;
            m_last_pc = pc;
            if (inst[6:0] == 7'h6b) begin
                trapped = 1;
                e_code  = trap_code_src;
                e_tpc   = pc;
            end
        end
        m_instr = m_instr + 64'(n);
        if (trapped) begin
            e_trapv = 1'b1;
            m_state = 1;
        end
`ifdef COMMIT_WATCHDOG_EN
        m_idle = (n != 0) ? 0 : m_idle + 1;
        if (!trapped && m_idle >= TIMEOUT) begin
            e_hang  = 1'b1;
            e_trapv = 1'b1;
            e_code  = 8'hFF;
            e_tpc   = m_last_pc;
            m_state = 1;
        end
`endif
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        check("out_valid",  128'(bus.out_valid), 128'(e_valid));
        check("out_skip",   128'(bus.out_skip),  128'(e_skip));
        check("out_wen",    128'(bus.out_wen),   128'(e_wen));
        check("out_pc",     bus.out_pc,          e_pc);
        check("out_wdata",  bus.out_wdata,       e_wdata);
        check("out_inst",   128'(bus.out_inst),  128'(e_inst));
        check("out_wdest",  128'(bus.out_wdest), 128'(e_wdest));
        check("trap_valid", 128'(trap_valid),    128'(e_trapv));
        check("trap_code",  128'(trap_code),     128'(e_code));
        check("trap_pc",    128'(trap_pc),       128'(e_tpc));
        check("cycle_cnt",  128'(cycle_cnt),     128'(m_cycle));
        check("instr_cnt",  128'(instr_cnt),     128'(m_instr));
        check("halted",     128'(halted),        128'(m_state == 2));
        check("hang",       128'(hang),          128'(e_hang));
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w,
                         input logic [63:0] p0, input logic [63:0] p1,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [4:0] d0, input logic [4:0] d1,
                         input logic [7:0] src);
        bus.in_valid  = v;
        bus.in_wen    = w;
        bus.in_pc     = {p1, p0};
        bus.in_inst   = {i1, i0};
        bus.in_wdest  = {d1, d0};
        bus.in_wdata  = {p1 ^ 64'h5A5A_1234_0F0F_C3C3, p0 ^ 64'hA5A5_4321_F0F0_3C3C};
        trap_code_src = src;
    endtask

    task automatic tick(input bit rst);
        reset = rst;
        model_step(rst);
        @(posedge clock);
        #1;
        cyc++;
        $display("txn %0d rst=%0b in_v=%b out_v=%b skip=%b wen=%b icnt=%0d ccnt=%0d trap=%0b code=%h halted=%0b hang=%0b",
                 cyc, rst, bus.in_valid, bus.out_valid, bus.out_skip, bus.out_wen,
                 instr_cnt, cycle_cnt, trap_valid, trap_code, halted, hang);
        compare_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        logic [1:0]  v, w;
        logic [63:0] p0, p1;
        logic [31:0] i0, i1;
        logic [4:0]  d0, d1;
        logic [7:0]  src;
        logic [1:0]  ev, es, ew;
        logic [63:0] ei;
        bit          et;
        logic [7:0]  ec;
        bit          eh;
    } vec_t;

    function automatic vec_t mkv(bit rst, logic [1:0] v, logic [1:0] w,
                                 logic [63:0] p0, logic [63:0] p1,
                                 logic [31:0] i0, logic [31:0] i1,
                                 logic [4:0] d0, logic [4:0] d1, logic [7:0] src,
                                 logic [1:0] ev, logic [1:0] es, logic [1:0] ew,
                                 logic [63:0] ei, bit et, logic [7:0] ec, bit eh);
        vec_t r;
        r.rst = rst; r.v = v; r.w = w; r.p0 = p0; r.p1 = p1; r.i0 = i0; r.i1 = i1;
        r.d0 = d0; r.d1 = d1; r.src = src; r.ev = ev; r.es = es; r.ew = ew;
        r.ei = ei; r.et = et; r.ec = ec; r.eh = eh;
        return r;
    endfunction

    vec_t vecs[$];
    int   halt_run;
    bit   wd_seen;
    int   wd_k;

    initial begin
        vecs.push_back(mkv(0, 2'b11, 2'b11, 64'h8000_0000, 64'h8000_0004, NOP, NOP, 5, 0, 8'h00, 2'b11, 2'b01, 2'b01, 2, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b01, 2'b01, 64'h8000_0000, 64'h8000_0004, NOP, NOP, 3, 0, 8'h00, 2'b01, 2'b00, 2'b01, 3, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b10, 2'b11, 64'h8000_0008, 64'h8000_000c, NOP, NOP, 1, 2, 8'h00, 2'b00, 2'b00, 2'b00, 3, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 64'h0,         64'h0,         NOP, NOP, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 3, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b11, 2'b10, 64'h8000_0010, 64'h8000_0014, NOP, NOP, 4, 7, 8'h00, 2'b11, 2'b00, 2'b10, 5, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b11, 2'b11, 64'h8000_0100, 64'h8000_0104, TRAPI, NOP, 1, 2, 8'h00, 2'b01, 2'b00, 2'b01, 6, 1, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b11, 2'b11, 64'h8000_0108, 64'h8000_010c, NOP, NOP, 1, 2, 8'h00, 2'b00, 2'b00, 2'b00, 6, 0, 8'h00, 1));
        vecs.push_back(mkv(1, 2'b11, 2'b11, 64'h8000_0000, 64'h8000_0004, TRAPI, NOP, 1, 2, 8'h11, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b01, 2'b01, 64'h8000_0000, 64'h8000_0004, NOP, NOP, 9, 0, 8'h00, 2'b01, 2'b01, 2'b01, 1, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b11, 2'b11, 64'h8000_0200, 64'h8000_0208, NOP, TRAPI, 1, 2, 8'h2a, 2'b11, 2'b00, 2'b11, 3, 1, 8'h2a, 0));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 64'h0,         64'h0,         NOP, NOP, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 3, 0, 8'h2a, 1));
        vecs.push_back(mkv(1, 2'b00, 2'b00, 64'h0,         64'h0,         NOP, NOP, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        vecs.push_back(mkv(1, 2'b01, 2'b01, 64'h8000_0000, 64'h8000_0004, TRAPI, NOP, 1, 0, 8'h33, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        vecs.push_back(mkv(0, 2'b01, 2'b01, 64'h8000_0000, 64'h8000_0004, NOP, NOP, 0, 0, 8'h00, 2'b01, 2'b01, 2'b00, 1, 0, 8'h00, 0));

        // Reset for 3 cycles, then one idle cycle
        drive(2'b00, 2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 5'd0, 5'd0, 8'h00);
        repeat (3) tick(1);
        tick(0);
        check("rst_cycle_cnt", 128'(cycle_cnt), 128'd1);
        check("rst_instr_cnt", 128'(instr_cnt), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_trap_valid", 128'(trap_valid), 128'd0);
        check("rst_halted", 128'(halted), 128'd0);

        // Directed table; the trap on lane0 happens at index 5, halt at index 6
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].p0, vecs[i].p1, vecs[i].i0, vecs[i].i1,
                  vecs[i].d0, vecs[i].d1, vecs[i].src);
            tick(vecs[i].rst);
            check($sformatf("v%0d_valid", i), 128'(bus.out_valid), 128'(vecs[i].ev));
            check($sformatf("v%0d_skip", i),  128'(bus.out_skip),  128'(vecs[i].es));
            check($sformatf("v%0d_wen", i),   128'(bus.out_wen),   128'(vecs[i].ew));
            check($sformatf("v%0d_icnt", i),  128'(instr_cnt),     128'(vecs[i].ei));
            check($sformatf("v%0d_trap", i),  128'(trap_valid),    128'(vecs[i].et));
            check($sformatf("v%0d_halt", i),  128'(halted),        128'(vecs[i].eh));
            if (vecs[i].et) check($sformatf("v%0d_code", i), 128'(trap_code), 128'(vecs[i].ec));
            if (i == 6) begin
                // Counters frozen across 10 cycles of valid input while halted
                for (int k = 0; k < 10; k++) begin
                    drive(2'b11, 2'b11, 64'h8000_0300 + 64'(k*8), 64'h8000_0304 + 64'(k*8),
                          NOP, TRAPI, 5'd3, 5'd4, 8'h77);
                    tick(0);
                    check("frozen_cycle", 128'(cycle_cnt), 128'd8);
                    check("frozen_instr", 128'(instr_cnt), 128'd6);
                    check("frozen_trap_pc", 128'(trap_pc), 128'h8000_0100);
                    check("frozen_valid", 128'(bus.out_valid), 128'd0);
                end
            end
        end

`ifdef COMMIT_WATCHDOG_EN
        // One commit, then silence until the watchdog fires
        tick(1);
        tick(1);
        drive(2'b01, 2'b00, 64'h8000_0040, 64'h8000_0044, NOP, NOP, 5'd0, 5'd0, 8'h00);
        tick(0);
        drive(2'b00, 2'b00, 64'h0, 64'h0, NOP, NOP, 5'd0, 5'd0, 8'h00);
        wd_seen = 0;
        wd_k = 0;
        for (int j = 1; j <= 30 && !wd_seen; j++) begin
            tick(0);
            if (trap_valid) begin
                wd_seen = 1;
                wd_k = j;
            end
        end
        check("wd_fired", 128'(wd_seen), 128'd1);
        check("wd_idle_cycles", 128'(wd_k), 128'd8);
        check("wd_hang", 128'(hang), 128'd1);
        check("wd_code", 128'(trap_code), 128'hFF);
        check("wd_pc", 128'(trap_pc), 128'h8000_0040);
        tick(0);
        check("wd_halted", 128'(halted), 128'd1);
        check("wd_trap_once", 128'(trap_valid), 128'd0);
        check("wd_hang_sticky", 128'(hang), 128'd1);
`endif

        // Randomized traffic against the model
        tick(1);
        tick(1);
        halt_run = 0;
        for (int n = 0; n < 1500; n++) begin
            logic [1:0]  v, w;
            logic [63:0] p0;
            logic [31:0] i0, i1;
            logic [4:0]  d0, d1;
            bit          rst;
            v  = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom_range(0, 3));
            w  = 2'($urandom_range(0, 3));
            p0 = ($urandom_range(0, 7) == 0) ? PC_START : {32'h0, $urandom};
            i0 = $urandom;
            i1 = $urandom;
            if ($urandom_range(0, 39) == 0) i0[6:0] = 7'h6b;
            if ($urandom_range(0, 39) == 0) i1[6:0] = 7'h6b;
            d0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            d1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rst = ($urandom_range(0, 149) == 0) || (halt_run > 3);
            drive(v, w, p0, p0 + 64'd4, i0, i1, d0, d1, 8'($urandom));
            tick(rst);
            halt_run = (m_state == 2) ? halt_run + 1 : 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
